// File: rtl/mesh_traffic_gen_pkg.sv
// Shared types and helpers for the mesh traffic generator and its flit checker.
package mesh_traffic_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_SWEEP = 1'b1
    } mode_e;

    // All-ones mask of w low bits.
    function automatic logic [31:0] coord_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Packs {dst_y, dst_x, src_y, src_x} into the low 2*(xw+yw) bits.
    function automatic logic [31:0] pack_header(input int xw, input int yw,
                                                input logic [31:0] dst_x,
                                                input logic [31:0] dst_y,
                                                input logic [31:0] src_x,
                                                input logic [31:0] src_y);
        return ((dst_y & coord_mask(yw)) << (2 * xw + yw))
             | ((dst_x & coord_mask(xw)) << (xw + yw))
             | ((src_y & coord_mask(yw)) << xw)
             |  (src_x & coord_mask(xw));
    endfunction

endpackage

// File: rtl/mesh_flit_checker.sv
// Receive-side checker: counts ejected flits and flags any flit whose
// destination field does not name this node.
module mesh_flit_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int XW         = 2,
    parameter int YW         = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XW-1:0]         my_x_i,
    input  logic [YW-1:0]         my_y_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [CNT_WIDTH-1:0]  rcvd_cnt_o,
    output logic                  err_o
);

    logic [YW-1:0]        flit_dst_y;
    logic [XW-1:0]        flit_dst_x;
    logic                 unused_payload;
    logic [CNT_WIDTH-1:0] rcvd_q, rcvd_d;
    logic                 err_q, err_d;

    assign flit_dst_y     = data_i[DATA_WIDTH-1 -: YW];
    assign flit_dst_x     = data_i[DATA_WIDTH-YW-1 -: XW];
    assign unused_payload = ^data_i[DATA_WIDTH-YW-XW-1:0];

    // Count every ejected flit; latch a misroute until reset.
    always_comb begin
        rcvd_d = rcvd_q + CNT_WIDTH'(valid_i);
        err_d  = err_q;
        if (valid_i && ((flit_dst_y != my_y_i) || (flit_dst_x != my_x_i))) begin
            err_d = 1'b1;
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcvd_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rcvd_q <= rcvd_d;
            err_q  <= err_d;
        end
    end

    assign rcvd_cnt_o = rcvd_q;
    assign err_o      = err_q;

endmodule

// File: rtl/mesh_traffic_gen.sv
// Mesh traffic generator: injects bursts of flits to a fixed destination or
// sweeping over every other node, and checks flits ejected at this node.
module mesh_traffic_gen
    import mesh_traffic_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int X_DIMENSION = 4,
    parameter int Y_DIMENSION = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int XW = ($clog2(X_DIMENSION) > 1) ? $clog2(X_DIMENSION) : 1,
    localparam int YW = ($clog2(Y_DIMENSION) > 1) ? $clog2(Y_DIMENSION) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XW-1:0]         my_x_i,
    input  logic [YW-1:0]         my_y_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [XW-1:0]         dest_x_i,
    input  logic [YW-1:0]         dest_y_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    input  logic [CNT_WIDTH-1:0]  gap_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  sent_cnt_o,
    output logic [CNT_WIDTH-1:0]  rcvd_cnt_o,
    output logic                  err_o
);

    localparam int            NW     = XW + YW;
    localparam int            HW     = 2 * NW;
    localparam int            SW     = DATA_WIDTH - HW;
    localparam logic [XW-1:0] X_LAST = XW'(X_DIMENSION - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_DIMENSION - 1);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [XW-1:0]        dst_x_q, dst_x_d;
    logic [YW-1:0]        dst_y_q, dst_y_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [SW-1:0]        seq_q, seq_d;
    logic                 ready_q;
    logic [HW-1:0]        hdr;
    logic [NW-1:0]        self_node;
    logic [NW-1:0]        sweep_first;
    logic [NW-1:0]        sweep_next;
    logic                 handshake;

    // Row-major successor of a node {y, x}: x advances first, wrapping to (0,0).
    function automatic logic [NW-1:0] node_step(input logic [NW-1:0] node);
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        {y, x} = node;
        if (x == X_LAST) begin
            x = '0;
            y = (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
            x = x + XW'(1);
        end
        return {y, x};
    endfunction

    // Sweep targets: first non-self node from (0,0), and the next non-self node.
    always_comb begin
        self_node   = {my_y_i, my_x_i};
        sweep_first = (self_node == '0) ? node_step('0) : '0;
        sweep_next  = node_step({dst_y_q, dst_x_q});
        if (sweep_next == self_node) begin
            sweep_next = node_step(sweep_next);
        end
    end

    assign handshake = (state_q == ST_SEND) && ready_i;
    assign hdr = HW'(pack_header(XW, YW, 32'(dst_x_q), 32'(dst_y_q),
                                 32'(my_x_i), 32'(my_y_i)));

    // Burst FSM: latch the request, send flits with optional gaps, pulse done.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dst_x_d   = dst_x_q;
        dst_y_d   = dst_y_q;
        count_d   = count_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        sent_d    = sent_q;
        seq_d     = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_e'(mode_i);
                    count_d = count_i;
                    gap_d   = gap_i;
                    sent_d  = '0;
                    seq_d   = '0;
                    if (mode_e'(mode_i) == MODE_SWEEP) begin
                        {dst_y_d, dst_x_d} = sweep_first;
                    end else begin
                        dst_x_d = dest_x_i;
                        dst_y_d = dest_y_i;
                    end
                    state_d = (count_i == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    sent_d = sent_q + CNT_WIDTH'(1);
                    seq_d  = seq_q + SW'(1);
                    if (mode_q == MODE_SWEEP) begin
                        {dst_y_d, dst_x_d} = sweep_next;
                    end
                    if (sent_q + CNT_WIDTH'(1) == count_q) begin
                        state_d = ST_DONE;
                    end else if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= CNT_WIDTH'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and burst registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_FIXED;
            dst_x_q   <= '0;
            dst_y_q   <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            sent_q    <= '0;
            seq_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dst_x_q   <= dst_x_d;
            dst_y_q   <= dst_y_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            sent_q    <= sent_d;
            seq_q     <= seq_d;
            ready_q   <= 1'b1;
        end
    end

    assign valid_o    = (state_q == ST_SEND);
    assign data_o     = valid_o ? {hdr, seq_q} : '0;
    assign busy_o     = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done_o     = (state_q == ST_DONE);
    assign ready_o    = ready_q;
    assign sent_cnt_o = sent_q;

    mesh_flit_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .XW         (XW),
        .YW         (YW),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_checker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .my_x_i     (my_x_i),
        .my_y_i     (my_y_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .rcvd_cnt_o (rcvd_cnt_o),
        .err_o      (err_o)
    );

endmodule

// File: tb/tb_mesh_traffic_gen.sv
// Self-checking bench for mesh_traffic_gen on the default 4x4, 32-bit build.
module tb_mesh_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  my_x_i = '0;
    logic [1:0]  my_y_i = '0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [1:0]  dest_x_i = '0;
    logic [1:0]  dest_y_i = '0;
    logic [15:0] count_i = '0;
    logic [15:0] gap_i = '0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] sent_cnt_o;
    logic [15:0] rcvd_cnt_o;
    logic        err_o;

    int n_chk = 0;
    int n_fail = 0;

    mesh_traffic_gen dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .my_x_i     (my_x_i),
        .my_y_i     (my_y_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .dest_x_i   (dest_x_i),
        .dest_y_i   (dest_y_i),
        .count_i    (count_i),
        .gap_i      (gap_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sent_cnt_o (sent_cnt_o),
        .rcvd_cnt_o (rcvd_cnt_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference flit: {dest y, dest x, src y, src x, 24-bit sequence}.
    function automatic logic [31:0] mk_flit(input int dx, input int dy,
                                            input int sx, input int sy, input int seq);
        return {dy[1:0], dx[1:0], sy[1:0], sx[1:0], seq[23:0]};
    endfunction

    // i-th destination of a sweep: row-major list of all nodes except self, repeating.
    function automatic void sweep_dest(input int i, input int mx, input int my,
                                       output int dx, output int dy);
        int k;
        int n;
        k  = i % 15;
        n  = 0;
        dx = 0;
        dy = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (!(x == mx && y == my)) begin
                    if (n == k) begin
                        dx = x;
                        dy = y;
                    end
                    n++;
                end
            end
        end
    endfunction

    // Input drivers for the mesh-side ready and the ejection port.
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
    int          sink_mode = 0;    // 0 directed queue, 1 random
    logic [31:0] sink_q[$];

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(3) != 0);
            default: ready_i = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        #2;
        if (sink_mode == 1) begin
            valid_i = 1'($urandom_range(1));
            data_i  = $urandom;
            if ($urandom_range(1) == 1) data_i[31:28] = {my_y_i, my_x_i};
        end else if (sink_q.size() > 0) begin
            valid_i = 1'b1;
            data_i  = sink_q.pop_front();
        end else begin
            valid_i = 1'b0;
            data_i  = '0;
        end
    end

    // Behavioural model: the burst is a queue of expected flits plus a count of
    // idle cycles still owed before the next flit may be offered.
    bit          m_on = 0;
    bit          m_rst_prev = 0;
    bit          m_active = 0;
    bit          m_done = 0;
    int          m_idle = 0;
    int          m_gap = 0;
    logic [31:0] m_q[$];
    logic [15:0] m_sent = '0;
    logic [15:0] m_rcvd = '0;
    logic        m_err = 1'b0;
    int          n_valid_seen = 0;
    int          n_busy_seen = 0;

    always @(negedge clk) begin
        bit was_done;
        int dx;
        int dy;
        if (m_on) begin
            chk("ready_o", ready_o, !m_rst_prev);
            chk("done_o", done_o, m_done);
            chk("busy_o", busy_o, m_active);
            chk("valid_o", valid_o, m_active && (m_idle == 0));
            if (m_active && m_idle == 0) chk("data_o", data_o, m_q[0]);
            if (m_rst_prev) chk("data_o_reset", data_o, 0);
            chk("sent_cnt_o", sent_cnt_o, m_sent);
            chk("rcvd_cnt_o", rcvd_cnt_o, m_rcvd);
            chk("err_o", err_o, m_err);
            if (valid_o) n_valid_seen++;
            if (busy_o) n_busy_seen++;
        end
        if (rst_i) begin
            m_on       = 1;
            m_rst_prev = 1;
            m_active   = 0;
            m_done     = 0;
            m_idle     = 0;
            m_q.delete();
            m_sent     = '0;
            m_rcvd     = '0;
            m_err      = 1'b0;
        end else if (m_on) begin
            was_done   = m_done;
            m_done     = 0;
            m_rst_prev = 0;
            if (m_active) begin
                if (m_idle > 0) begin
                    m_idle--;
                end else if (ready_i) begin
                    void'(m_q.pop_front());
                    m_sent++;
                    if (m_q.size() == 0) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_idle = m_gap;
                    end
                end
            end else if (!was_done && start_i) begin
                m_sent = '0;
                m_gap  = int'(gap_i);
                m_q.delete();
                for (int i = 0; i < int'(count_i); i++) begin
                    if (mode_i) sweep_dest(i, int'(my_x_i), int'(my_y_i), dx, dy);
                    else begin
                        dx = int'(dest_x_i);
                        dy = int'(dest_y_i);
                    end
                    m_q.push_back(mk_flit(dx, dy, int'(my_x_i), int'(my_y_i), i));
                end
                if (count_i == 0) m_done = 1;
                else begin
                    m_active = 1;
                    m_idle   = 0;
                end
            end
            if (valid_i) begin
                m_rcvd++;
                if (data_i[31:28] != {my_y_i, my_x_i}) m_err = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit md, input int dx, input int dy, input int cnt, input int gp);
        mode_i   = md;
        dest_x_i = 2'(dx);
        dest_y_i = 2'(dy);
        count_i  = 16'(cnt);
        gap_i    = 16'(gp);
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk(nm, seen, 1);
        tick();
    endtask

    initial begin
        int dx;
        int dy;
        int cnt;

        // Model pins: literal flits and sweep order.
        chk("pin_flit_first", mk_flit(3, 1, 0, 1, 0), 32'h7400_0000);
        chk("pin_flit_last", mk_flit(3, 1, 0, 1, 3), 32'h7400_0003);
        sweep_dest(0, 0, 0, dx, dy);
        chk("pin_sweep0", {dy[1:0], dx[1:0]}, 4'b0001);
        sweep_dest(14, 0, 0, dx, dy);
        chk("pin_sweep14", {dy[1:0], dx[1:0]}, 4'b1111);
        sweep_dest(15, 0, 0, dx, dy);
        chk("pin_sweep15", mk_flit(dx, dy, 0, 0, 15), 32'h1000_000F);

        // Reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", ready_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_err", err_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // Fixed burst, back to back.
        my_x_i = 2'd0;
        my_y_i = 2'd1;
        n_valid_seen = 0;
        do_start(1'b0, 3, 1, 4, 0);
        wait_done("done_fixed_gap0");
        chk("fixed_gap0_valid_cycles", n_valid_seen, 4);
        chk("fixed_gap0_sent", sent_cnt_o, 4);

        // Fixed burst with two idle cycles between flits.
        n_busy_seen = 0;
        n_valid_seen = 0;
        do_start(1'b0, 3, 1, 4, 2);
        wait_done("done_fixed_gap2");
        chk("fixed_gap2_valid_cycles", n_valid_seen, 4);
        chk("fixed_gap2_busy_cycles", n_busy_seen, 10);

        // Backpressure for five cycles after the first flit.
        n_valid_seen = 0;
        do_start(1'b0, 3, 1, 4, 0);
        tick();
        ready_mode = 2;
        repeat (5) tick();
        ready_mode = 0;
        wait_done("done_stall");
        chk("stall_valid_cycles", n_valid_seen, 9);
        chk("stall_sent", sent_cnt_o, 4);

        // Sweep from (0,0) over a full round plus one.
        my_x_i = 2'd0;
        my_y_i = 2'd0;
        n_valid_seen = 0;
        do_start(1'b1, 0, 0, 16, 0);
        wait_done("done_sweep16");
        chk("sweep16_valid_cycles", n_valid_seen, 16);

        // Start pulses during a burst are ignored.
        do_start(1'b0, 2, 3, 3, 2);
        tick();
        do_start(1'b1, 1, 1, 9, 0);
        wait_done("done_ignore_start");
        chk("ignore_start_sent", sent_cnt_o, 3);

        // Empty burst.
        n_valid_seen = 0;
        do_start(1'b0, 1, 1, 0, 0);
        @(negedge clk);
        chk("count0_done", done_o, 1);
        chk("count0_sent", sent_cnt_o, 0);
        tick();
        chk("count0_no_valid", n_valid_seen, 0);

        // Randomised bursts with random backpressure and random ejected traffic.
        ready_mode = 1;
        sink_mode  = 1;
        for (int b = 0; b < 40; b++) begin
            my_x_i = 2'($urandom_range(3));
            my_y_i = 2'($urandom_range(3));
            cnt    = int'($urandom_range(6));
            do_start(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)),
                     cnt, int'($urandom_range(3)));
            wait_done("done_random");
            repeat (int'($urandom_range(2))) tick();
        end
        ready_mode = 0;
        sink_mode  = 0;
        tick();

        // Ejection: three flits for this node, one misrouted.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        my_x_i = 2'd2;
        my_y_i = 2'd1;
        sink_q.push_back(32'h6123_4567);
        sink_q.push_back(32'h6000_0001);
        sink_q.push_back(32'h6FFF_FFFF);
        sink_q.push_back(32'h3000_0000);
        repeat (6) tick();
        chk("sink_rcvd", rcvd_cnt_o, 4);
        chk("sink_err", err_o, 1);
        repeat (4) tick();
        chk("sink_err_sticky", err_o, 1);

        // Reset in the middle of a burst.
        do_start(1'b0, 1, 0, 5, 1);
        repeat (3) tick();
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ready", ready_o, 0);
        chk("midrst_sent", sent_cnt_o, 0);
        chk("midrst_rcvd", rcvd_cnt_o, 0);
        chk("midrst_err", err_o, 0);
        tick();
        rst_i = 1'b0;
        repeat (8) tick();
        chk("midrst_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
